// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: flag bundle, stage
// state encoding and the active-low 7-segment glyph table.
package alu_pkg;

  typedef struct packed {
    logic negativo;
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low 7-segment decoder ({g..a}).
module hex_to_7seg
  import alu_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_HEX[hex];

endmodule

// File: rtl/alu_result_stage.sv
// Registered valid/ready output stage for the 4-bit ALU: result, flags, sticky
// history, op counter and zero-flag check. ALU_RESULT_SEVENSEG_EN adds a
// registered hex display of the held result on seg_n.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   y_in,
  input  logic               zero_in,
  input  logic               negativo_in,
  input  logic               carry_in,
  input  logic               overflow_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y_out,
  output logic [3:0]         flags_out,
  output logic [3:0]         sticky_flags,
  input  logic               clr_sticky,
  output logic [COUNT_W-1:0] op_count,
  output logic               zero_err,
  output logic [6:0]         seg_n
);

  stage_state_t       state, state_next;
  alu_flags_t         flags_in, flags_q, sticky_q;
  logic [WIDTH-1:0]   y_q;
  logic [COUNT_W-1:0] count_q;
  logic               zero_err_q;
  logic               accept;
  logic               zero_mismatch;

  // Ready looks at out_ready directly so a full stage can drain and refill on one edge.
  assign in_ready      = !rst && (state == EMPTY || out_ready);
  assign accept        = in_valid && in_ready;
  assign flags_in      = {negativo_in, zero_in, carry_in, overflow_in};
  assign zero_mismatch = zero_in != (y_in == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (accept) state_next = FULL;
               else if (out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      flags_q    <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
      zero_err_q <= 1'b0;
    end else begin
      if (accept) begin
        y_q     <= y_in;
        flags_q <= flags_in;
        count_q <= count_q + COUNT_W'(1);
      end
      // A clear on the same edge as an accept still keeps the new flags.
      if (accept)          sticky_q <= (clr_sticky ? '0 : sticky_q) | flags_in;
      else if (clr_sticky) sticky_q <= '0;
      if (accept && zero_mismatch) zero_err_q <= 1'b1;
      else if (clr_sticky)         zero_err_q <= 1'b0;
    end
  end

  assign y_out        = y_q;
  assign flags_out    = flags_q;
  assign sticky_flags = sticky_q;
  assign op_count     = count_q;
  assign zero_err     = zero_err_q;

`ifdef ALU_RESULT_SEVENSEG_EN
  logic [6:0] glyph;
  logic [6:0] seg_q;

  hex_to_7seg u_hex_to_7seg (
    .hex   (y_in[3:0]),
    .seg_n (glyph)
  );

  // Tracks y_out: loads with the data, blanks when the stage drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             seg_q <= SEG_BLANK;
    else if (accept)                     seg_q <= glyph;
    else if (state == FULL && out_ready) seg_q <= SEG_BLANK;
  end

  assign seg_n = seg_q;
`else
  assign seg_n = SEG_BLANK;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scoreboard queue of accepted
// results plus a small model of sticky flags, zero_err and op_count.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] y_in = '0;
  logic       zero_in = 1'b0, negativo_in = 1'b0, carry_in = 1'b0, overflow_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] y_out;
  logic [3:0] flags_out;
  logic [3:0] sticky_flags;
  logic       clr_sticky = 1'b0;
  logic [7:0] op_count;
  logic       zero_err;
  logic [6:0] seg_n;

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] f;
  } xfer_t;

  xfer_t      exp_q[$];
  logic [3:0] m_sticky;
  logic       m_zerr;
  logic [7:0] m_count;
  int         checks = 0;
  int         errors = 0;

  alu_result_stage #(.WIDTH(4), .COUNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .y_in         (y_in),
    .zero_in      (zero_in),
    .negativo_in  (negativo_in),
    .carry_in     (carry_in),
    .overflow_in  (overflow_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y_out        (y_out),
    .flags_out    (flags_out),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .op_count     (op_count),
    .zero_err     (zero_err),
    .seg_n        (seg_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg();
`ifdef ALU_RESULT_SEVENSEG_EN
    if (exp_q.size() != 0) return glyph(exp_q[0].y);
`endif
    return 7'h7F;
  endfunction

  // Drive one cycle of stimulus (called 1ns after a rising edge), advance past
  // the next edge and update the scoreboard/model. f = {neg, zero, carry, ovf}.
  task automatic step(input logic v, input logic [3:0] y, input logic [3:0] f,
                      input logic ordy, input logic clr);
    logic full, acc;
    in_valid = v; y_in = y; out_ready = ordy; clr_sticky = clr;
    {negativo_in, zero_in, carry_in, overflow_in} = f;
    full = exp_q.size() != 0;
    acc  = v && (!full || ordy);
    @(posedge clk); #1;
    if (full && ordy) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back('{y: y, f: f});
      m_count++;
    end
    if (acc)      m_sticky = (clr ? 4'b0000 : m_sticky) | f;
    else if (clr) m_sticky = 4'b0000;
    if (acc && (f[2] != (y == 4'd0))) m_zerr = 1'b1;
    else if (clr)                     m_zerr = 1'b0;
    in_valid = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    m_sticky = '0; m_zerr = 1'b0; m_count = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL idle_op_count got %0d exp 0", op_count); end
    checks++; if (sticky_flags !== 4'b0) begin errors++; $display("FAIL idle_sticky got %b exp 0000", sticky_flags); end
    checks++; if ({y_out, flags_out, zero_err} !== 9'd0) begin errors++; $display("FAIL idle_data got %h exp 0", {y_out, flags_out, zero_err}); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL idle_seg got %h exp 7f", seg_n); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    step(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (y_out !== exp_q[0].y) begin errors++; $display("FAIL single_y got %h exp %h", y_out, exp_q[0].y); end
    checks++; if (flags_out !== exp_q[0].f) begin errors++; $display("FAIL single_flags got %b exp %b", flags_out, exp_q[0].f); end
    checks++; if (op_count !== m_count) begin errors++; $display("FAIL single_count got %0d exp %0d", op_count, m_count); end
    checks++; if (seg_n !== exp_seg()) begin errors++; $display("FAIL single_seg got %h exp %h", seg_n, exp_seg()); end
    // Held with out_ready low: an offered transfer must be refused.
    in_valid = 1'b1; out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL held_in_ready got %b exp 0", in_ready); end
    step(1'b1, 4'h5, 4'b0000, 1'b0, 1'b0);
    checks++; if (y_out !== 4'd8 || y_out !== exp_q[0].y) begin errors++; $display("FAIL held_y got %h exp 8", y_out); end
    checks++; if (op_count !== m_count) begin errors++; $display("FAIL held_count got %0d exp %0d", op_count, m_count); end
    step(1'b0, 4'h0, 4'b0000, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    checks++; if (seg_n !== exp_seg()) begin errors++; $display("FAIL drain_seg got %h exp %h", seg_n, exp_seg()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] start;
    start = m_count;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd3, 4'b0000, 1'b0, 1'b0);
      checks++; if (y_out !== 4'd3) begin errors++; $display("FAIL stall_y cyc %0d got %h exp 3", i, y_out); end
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d got %b exp 1", i, in_ready); end
      step(1'b1, 4'(4 + i), 4'b0000, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || y_out !== exp_q[0].y) begin errors++; $display("FAIL stream_y cyc %0d got %b/%h exp 1/%h", i, out_valid, y_out, exp_q[0].y); end
    end
    checks++; if (op_count !== 8'(start + 8'd5)) begin errors++; $display("FAIL stream_count got %0d exp %0d", op_count, 8'(start + 8'd5)); end
    step(1'b0, 4'h0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_sticky();
    step(1'b0, 4'h0, 4'b0000, 1'b1, 1'b1);
    checks++; if (sticky_flags !== 4'b0000) begin errors++; $display("FAIL sticky_clear got %b exp 0000", sticky_flags); end
    step(1'b1, 4'h1, 4'b0010, 1'b1, 1'b0);
    checks++; if (sticky_flags !== m_sticky) begin errors++; $display("FAIL sticky_carry got %b exp %b", sticky_flags, m_sticky); end
    step(1'b1, 4'h2, 4'b0001, 1'b1, 1'b1);
    checks++; if (sticky_flags !== 4'b0001 || sticky_flags !== m_sticky) begin errors++; $display("FAIL sticky_clr_accept got %b exp 0001", sticky_flags); end
  endtask

  task automatic test_zero();
    step(1'b1, 4'h0, 4'b0000, 1'b1, 1'b0);
    checks++; if (zero_err !== 1'b1) begin errors++; $display("FAIL zero_err_set got %b exp 1", zero_err); end
    step(1'b0, 4'h0, 4'b0000, 1'b0, 1'b1);
    checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL zero_err_clr got %b exp 0", zero_err); end
    step(1'b1, 4'h5, 4'b0100, 1'b1, 1'b1);
    checks++; if (zero_err !== m_zerr || zero_err !== 1'b1) begin errors++; $display("FAIL zero_err_set_wins got %b exp 1", zero_err); end
    step(1'b1, 4'h0, 4'b0100, 1'b1, 1'b1);
    checks++; if (zero_err !== m_zerr) begin errors++; $display("FAIL zero_err_consistent got %b exp %b", zero_err, m_zerr); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] y;
      y = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), y, {y[3], (y == 4'd0) ^ ($urandom_range(0, 7) == 0), 2'($urandom)},
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", i, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({y_out, flags_out} !== {exp_q[0].y, exp_q[0].f}) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", i, {y_out, flags_out}, {exp_q[0].y, exp_q[0].f}); end
      end
      checks++; if ({op_count, sticky_flags, zero_err} !== {m_count, m_sticky, m_zerr}) begin errors++; $display("FAIL b2b_state cyc %0d got %h exp %h", i, {op_count, sticky_flags, zero_err}, {m_count, m_sticky, m_zerr}); end
      checks++; if (seg_n !== exp_seg()) begin errors++; $display("FAIL b2b_seg cyc %0d got %h exp %h", i, seg_n, exp_seg()); end
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 4'(i), {1'b0, (4'(i) == 4'd0), 2'b00}, 1'b1, 1'b0);
      if (i == 254) begin
        checks++; if (op_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", op_count); end
      end
    end
    checks++; if (op_count !== 8'd0 || m_count !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", op_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_full got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b exp 0", out_valid); end
    checks++; if (y_out !== 4'd0) begin errors++; $display("FAIL async_rst_y got %h exp 0", y_out); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL async_rst_seg got %h exp 7f", seg_n); end
  endtask

  initial begin
    m_sticky = '0; m_zerr = 1'b0; m_count = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_sticky();
    test_zero();
    test_back_to_back();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
